// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multicycle MIPS main control FSM with memory handshake and retire counter
module mc_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic [1:0]       pcsource,
  output logic             aluop1,
  output logic             aluop0,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             regwrite,
  output logic             regdst,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_BEQ_EX   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic             illegal_q;
  logic             illegal_d;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  // Raw enables before the reset gate; muxes and aluop pass straight through.
  logic pcwrite_raw;
  logic pcwritecond_raw;
  logic memread_raw;
  logic memwrite_raw;
  logic irwrite_raw;
  logic regwrite_raw;

  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign instr_cnt  = cnt_q;

  // Next-state decode; op only matters in DECODE and MEMADR, unused codes recover to FETCH.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_RTYPE_EX;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BEQ_EX;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_RTYPE_WB: state_d = S_FETCH;
      S_BEQ_EX:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state; a stalled store waits for mem_ready.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RTYPE_WB, S_BEQ_EX, S_JUMP, S_ADDI_WB: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  // State, illegal-opcode pulse and retire counter; reset abandons any in-flight access uncounted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath controls are a pure function of state (plus mem_ready in FETCH).
  always_comb begin
    pcwrite_raw     = 1'b0;
    pcwritecond_raw = 1'b0;
    memread_raw     = 1'b0;
    memwrite_raw    = 1'b0;
    irwrite_raw     = 1'b0;
    regwrite_raw    = 1'b0;
    iord            = 1'b0;
    memtoreg        = 1'b0;
    pcsource        = 2'b00;
    aluop1          = 1'b0;
    aluop0          = 1'b0;
    alusrca         = 1'b0;
    alusrcb         = 2'b00;
    regdst          = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread_raw = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite_raw = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread_raw = 1'b1;
        iord        = 1'b1;
      end
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        memwrite_raw = 1'b1;
        iord         = 1'b1;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
      end
      S_RTYPE_WB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      S_BEQ_EX: begin
        alusrca         = 1'b1;
        aluop0          = 1'b1;
        pcwritecond_raw = 1'b1;
        pcsource        = 2'b01;
      end
      S_JUMP: begin
        pcwrite_raw = 1'b1;
        pcsource    = 2'b10;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDI_WB: begin
        regwrite_raw = 1'b1;
      end
      default: begin
        pcwrite_raw = 1'b0;
      end
    endcase
  end

  // Reset suppresses every write/request enable immediately, even mid-access.
  always_comb begin
    pcwrite     = pcwrite_raw     & rst_n;
    pcwritecond = pcwritecond_raw & rst_n;
    memread     = memread_raw     & rst_n;
    memwrite    = memwrite_raw    & rst_n;
    irwrite     = irwrite_raw     & rst_n;
    regwrite    = regwrite_raw    & rst_n;
  end

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - scoreboard bench for mc_main_control
module tb_mc_main_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = 6'b111111;
  logic        mem_ready = 1'b1;
  logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
  logic [1:0]  pcsource;
  logic        aluop1, aluop0, alusrca;
  logic [1:0]  alusrcb;
  logic        regwrite, regdst;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_cnt;

  mc_main_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .pcsource(pcsource), .aluop1(aluop1), .aluop0(aluop0),
    .alusrca(alusrca), .alusrcb(alusrcb), .regwrite(regwrite), .regdst(regdst),
    .state(state), .illegal_op(illegal_op), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Control word field order: pw pwc iord mr mw m2r irw pcs[1:0] a1 a0 asa asb[1:0] rw rd
  localparam logic [15:0] C_FETCH   = 16'b1_0_0_1_0_0_1_00_0_0_0_01_0_0;
  localparam logic [15:0] C_FWAIT   = 16'b0_0_0_1_0_0_0_00_0_0_0_01_0_0;
  localparam logic [15:0] C_FRST    = 16'b0_0_0_0_0_0_0_00_0_0_0_01_0_0;
  localparam logic [15:0] C_DECODE  = 16'b0_0_0_0_0_0_0_00_0_0_0_11_0_0;
  localparam logic [15:0] C_MEMADR  = 16'b0_0_0_0_0_0_0_00_0_0_1_10_0_0;
  localparam logic [15:0] C_MEMRD   = 16'b0_0_1_1_0_0_0_00_0_0_0_00_0_0;
  localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_0_1_0_00_0_0_0_00_1_0;
  localparam logic [15:0] C_MEMWR   = 16'b0_0_1_0_1_0_0_00_0_0_0_00_0_0;
  localparam logic [15:0] C_MEMWRR  = 16'b0_0_1_0_0_0_0_00_0_0_0_00_0_0;
  localparam logic [15:0] C_REX     = 16'b0_0_0_0_0_0_0_00_1_0_1_00_0_0;
  localparam logic [15:0] C_RWB     = 16'b0_0_0_0_0_0_0_00_0_0_0_00_1_1;
  localparam logic [15:0] C_BEQ     = 16'b0_1_0_0_0_0_0_01_0_1_1_00_0_0;
  localparam logic [15:0] C_JUMP    = 16'b1_0_0_0_0_0_0_10_0_0_0_00_0_0;
  localparam logic [15:0] C_AEX     = 16'b0_0_0_0_0_0_0_00_0_0_1_10_0_0;
  localparam logic [15:0] C_AWB     = 16'b0_0_0_0_0_0_0_00_0_0_0_00_1_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [15:0] act_ctl;
  assign act_ctl = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                    pcsource, aluop1, aluop0, alusrca, alusrcb, regwrite, regdst};

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (state !== e.st) begin
        errors++;
        $display("FAIL cyc%0d state act %0d exp %0d", cyc, state, e.st);
      end
      if (act_ctl !== e.ctl) begin
        errors++;
        $display("FAIL cyc%0d ctl act %b exp %b", cyc, act_ctl, e.ctl);
      end
      if (illegal_op !== e.ill) begin
        errors++;
        $display("FAIL cyc%0d illegal_op act %b exp %b", cyc, illegal_op, e.ill);
      end
      if (instr_cnt !== e.cnt) begin
        errors++;
        $display("FAIL cyc%0d instr_cnt act %0d exp %0d", cyc, instr_cnt, e.cnt);
      end
      cyc++;
    end
  end

  // Drive one cycle of inputs just after the edge and queue the outputs expected in that cycle.
  task automatic step(input logic [3:0] st, input logic [15:0] ctl, input logic ill,
                      input logic [31:0] cnt, input logic [5:0] o, input logic mr, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    op = o;
    mem_ready = mr;
    rst_n = rn;
    e.st = st; e.ctl = ctl; e.ill = ill; e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    // reset, two cycles, mem_ready high
    step(4'd0, C_FRST, 1'b0, 32'd0, BAD, 1'b1, 1'b0);
    step(4'd0, C_FRST, 1'b0, 32'd0, BAD, 1'b1, 1'b0);
    // lw: 0,1,2,3,4 then retire
    step(4'd0, C_FETCH,  1'b0, 32'd0, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd0, LW,  1'b1, 1'b1);
    step(4'd2, C_MEMADR, 1'b0, 32'd0, LW,  1'b1, 1'b1);
    step(4'd3, C_MEMRD,  1'b0, 32'd0, BAD, 1'b1, 1'b1);
    step(4'd4, C_MEMWB,  1'b0, 32'd0, BAD, 1'b1, 1'b1);
    // R-type with 3-cycle fetch stall; op garbage outside DECODE
    step(4'd0, C_FWAIT,  1'b0, 32'd1, BAD, 1'b0, 1'b1);
    step(4'd0, C_FWAIT,  1'b0, 32'd1, BAD, 1'b0, 1'b1);
    step(4'd0, C_FWAIT,  1'b0, 32'd1, BAD, 1'b0, 1'b1);
    step(4'd0, C_FETCH,  1'b0, 32'd1, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd1, RT,  1'b1, 1'b1);
    step(4'd6, C_REX,    1'b0, 32'd1, BAD, 1'b1, 1'b1);
    step(4'd7, C_RWB,    1'b0, 32'd1, LW,  1'b1, 1'b1);
    // beq
    step(4'd0, C_FETCH,  1'b0, 32'd2, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd2, BEQ, 1'b1, 1'b1);
    step(4'd8, C_BEQ,    1'b0, 32'd2, BAD, 1'b1, 1'b1);
    // illegal opcode: pulse in following FETCH, no retire
    step(4'd0, C_FETCH,  1'b0, 32'd3, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd3, BAD, 1'b1, 1'b1);
    step(4'd0, C_FETCH,  1'b1, 32'd3, BAD, 1'b1, 1'b1);
    // jump
    step(4'd1, C_DECODE, 1'b0, 32'd3, JMP, 1'b1, 1'b1);
    step(4'd9, C_JUMP,   1'b0, 32'd3, BAD, 1'b1, 1'b1);
    // addi
    step(4'd0, C_FETCH,  1'b0, 32'd4, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd4, ADDI, 1'b1, 1'b1);
    step(4'd10, C_AEX,   1'b0, 32'd4, BAD, 1'b1, 1'b1);
    step(4'd11, C_AWB,   1'b0, 32'd4, BAD, 1'b1, 1'b1);
    // sw with one stall cycle in MEMWR
    step(4'd0, C_FETCH,  1'b0, 32'd5, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd5, SW,  1'b1, 1'b1);
    step(4'd2, C_MEMADR, 1'b0, 32'd5, SW,  1'b1, 1'b1);
    step(4'd5, C_MEMWR,  1'b0, 32'd5, BAD, 1'b0, 1'b1);
    step(4'd5, C_MEMWR,  1'b0, 32'd5, BAD, 1'b1, 1'b1);
    // sw aborted by reset while stalled in MEMWR
    step(4'd0, C_FETCH,  1'b0, 32'd6, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd6, SW,  1'b1, 1'b1);
    step(4'd2, C_MEMADR, 1'b0, 32'd6, SW,  1'b1, 1'b1);
    step(4'd5, C_MEMWR,  1'b0, 32'd6, BAD, 1'b0, 1'b1);
    step(4'd5, C_MEMWRR, 1'b0, 32'd6, BAD, 1'b1, 1'b0);
    step(4'd0, C_FETCH,  1'b0, 32'd0, BAD, 1'b1, 1'b1);
    step(4'd1, C_DECODE, 1'b0, 32'd0, BAD, 1'b1, 1'b1);
    step(4'd0, C_FETCH,  1'b1, 32'd0, BAD, 1'b1, 1'b1);
    // drain scoreboard with a bounded wait
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending act %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
